// File: rtl/pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : pixel_shifter
// Purpose  : Video pixel serializer. Accepts parallel graphics words over a
//            valid/ready handshake into a one-word holding register, then
//            shifts them out one pixel per pix_en cycle (MSB or LSB first,
//            chosen per word). Pulses word_done after each word's last pixel
//            and flags underrun when pixels are requested with nothing loaded.
// Ports    : clk          - system clock, rising edge
//            clr          - synchronous active-high reset
//            in_data_i    - parallel word from upstream latch
//            in_dir_i     - shift order of this word (0 MSB first, 1 LSB first)
//            in_valid_i   - upstream word available
//            in_ready_o   - holding register empty
//            pix_en_i     - pixel clock enable
//            pix_out_o    - current pixel bit
//            pix_valid_o  - shifter holds a word, pix_out_o meaningful
//            word_done_o  - one-cycle pulse after a word's last pixel
//            underrun_o   - sticky: pix_en_i seen while idle
// Revision : 1.0 - initial release
// ============================================================================
module pixel_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_dir_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             pix_en_i,
  output logic             pix_out_o,
  output logic             pix_valid_o,
  output logic             word_done_o,
  output logic             underrun_o
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] hold_data_q;
  logic             hold_dir_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] sh_data_q;
  logic             sh_dir_q;
  logic [CW-1:0]    cnt_q;
  logic             pix_out_q;
  logic             pix_valid_q;
  logic             word_done_q;
  logic             underrun_q;

  logic             accept_d;
  logic [WIDTH-1:0] sh_data_d;
  logic             sh_first_d;
  logic             hold_first_d;

  // clr gates ready so nothing is accepted on a reset edge.
  assign in_ready_o = !hold_full_q && !clr;
  assign accept_d   = in_valid_i && in_ready_o;

  // Shift toward the output end with zero fill.
  assign sh_data_d    = sh_dir_q ? {1'b0, sh_data_q[WIDTH-1:1]}
                                 : {sh_data_q[WIDTH-2:0], 1'b0};
  // Output bit that will be presented after the next shift / load.
  assign sh_first_d   = sh_dir_q ? sh_data_d[0] : sh_data_d[WIDTH-1];
  assign hold_first_d = hold_dir_q ? hold_data_q[0] : hold_data_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      hold_data_q <= '0;
      hold_dir_q  <= 1'b0;
      hold_full_q <= 1'b0;
      sh_data_q   <= '0;
      sh_dir_q    <= 1'b0;
      cnt_q       <= '0;
      pix_out_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      word_done_q <= 1'b0;

      // Accept only when empty; a hold-to-shifter move needs hold full, so the
      // two never coincide and the hold_full updates below cannot conflict.
      if (accept_d) begin
        hold_data_q <= in_data_i;
        hold_dir_q  <= in_dir_i;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (pix_en_i) begin
            underrun_q <= 1'b1;
          end
          if (hold_full_q) begin
            sh_data_q   <= hold_data_q;
            sh_dir_q    <= hold_dir_q;
            cnt_q       <= CNT_LAST;
            hold_full_q <= 1'b0;
            pix_out_q   <= hold_first_d;
            pix_valid_q <= 1'b1;
            state_q     <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (pix_en_i) begin
            if (cnt_q != '0) begin
              sh_data_q <= sh_data_d;
              cnt_q     <= cnt_q - CW'(1);
              pix_out_q <= sh_first_d;
            end else begin
              word_done_q <= 1'b1;
              if (hold_full_q) begin
                // Seamless reload: no gap pixel between words.
                sh_data_q   <= hold_data_q;
                sh_dir_q    <= hold_dir_q;
                cnt_q       <= CNT_LAST;
                hold_full_q <= 1'b0;
                pix_out_q   <= hold_first_d;
              end else begin
                pix_out_q   <= 1'b0;
                pix_valid_q <= 1'b0;
                state_q     <= S_IDLE;
              end
            end
          end
        end

        default: begin
          state_q     <= S_IDLE;
          pix_out_q   <= 1'b0;
          pix_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_out_o   = pix_out_q;
  assign pix_valid_o = pix_valid_q;
  assign word_done_o = word_done_q;
  assign underrun_o  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_shifter
// Purpose  : Self-checking bench for pixel_shifter. A word-level reference
//            model (current word + pixel index, one hold slot) predicts every
//            output each cycle; directed sequences plus a randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_shifter;

  localparam int W = 8;

  logic         clk;
  logic         clr;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         in_valid;
  logic         in_ready;
  logic         pix_en;
  logic         pix_out;
  logic         pix_valid;
  logic         word_done;
  logic         underrun;

  pixel_shifter #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .in_data_i   (in_data),
    .in_dir_i    (in_dir),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .pix_en_i    (pix_en),
    .pix_out_o   (pix_out),
    .pix_valid_o (pix_valid),
    .word_done_o (word_done),
    .underrun_o  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a word being emitted plus the index of its current pixel.
  logic         m_hold_full, m_hold_dir, m_act, m_dir, m_done, m_under;
  logic [W-1:0] m_hold_word, m_word;
  int           m_pos;

  // Upstream feeder queue.
  logic [W-1:0] q_data[$];
  logic         q_dir[$];
  logic [15:0]  rec;

  function automatic logic m_pix();
    if (!m_act) return 1'b0;
    return m_dir ? m_word[m_pos] : m_word[W-1-m_pos];
  endfunction

  task automatic model_step(input logic c, input logic v, input logic [W-1:0] d,
                            input logic dr, input logic en);
    logic old_full;
    if (c) begin
      m_hold_full = 0; m_act = 0; m_done = 0; m_under = 0; m_pos = 0;
      return;
    end
    old_full = m_hold_full;
    m_done   = 0;
    if (!m_act) begin
      if (en) m_under = 1;
      if (old_full) begin
        m_act = 1; m_word = m_hold_word; m_dir = m_hold_dir; m_pos = 0; m_hold_full = 0;
      end
    end else if (en) begin
      if (m_pos == W-1) begin
        m_done = 1;
        if (old_full) begin
          m_word = m_hold_word; m_dir = m_hold_dir; m_pos = 0; m_hold_full = 0;
        end else begin
          m_act = 0;
        end
      end else begin
        m_pos++;
      end
    end
    if (v && !old_full) begin
      m_hold_full = 1; m_hold_word = d; m_hold_dir = dr;
    end
  endtask

  // One clock cycle: drive, record consumed pixel, clock, model, compare.
  task automatic cyc(input logic c, input logic en);
    logic acc;
    clr      = c;
    pix_en   = en;
    in_valid = (q_data.size() > 0);
    in_data  = in_valid ? q_data[0] : W'($urandom);
    in_dir   = in_valid ? q_dir[0]  : 1'($urandom);
    if (pix_valid === 1'b1 && en) rec = {rec[14:0], pix_out};
    acc = in_valid && !m_hold_full && !c;
    @(posedge clk);
    model_step(c, in_valid, in_data, in_dir, en);
    if (acc) begin
      void'(q_data.pop_front());
      void'(q_dir.pop_front());
    end
    #1;
    check("in_ready",  {31'd0, in_ready},  {31'd0, !m_hold_full && !clr});
    check("pix_valid", {31'd0, pix_valid}, {31'd0, m_act});
    check("pix_out",   {31'd0, pix_out},   {31'd0, m_pix()});
    check("word_done", {31'd0, word_done}, {31'd0, m_done});
    check("underrun",  {31'd0, underrun},  {31'd0, m_under});
  endtask

  task automatic push(input logic [W-1:0] d, input logic dr);
    q_data.push_back(d);
    q_dir.push_back(dr);
  endtask

  task automatic do_reset();
    q_data.delete();
    q_dir.delete();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rec = '0;
  endtask

  initial begin
    clr = 1'b1; pix_en = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
    m_hold_full = 0; m_hold_dir = 0; m_act = 0; m_dir = 0; m_done = 0;
    m_under = 0; m_hold_word = '0; m_word = '0; m_pos = 0; rec = '0;

    // Reset state and first cycle after reset.
    do_reset();
    cyc(1'b0, 1'b0);

    // 0xB4 MSB first: 1,0,1,1,0,1,0,0
    do_reset();
    push(8'hB4, 1'b0);
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b1);
    check("b4_msb_seq", {24'd0, rec[7:0]}, 32'hB4);

    // 0xB4 LSB first: 0,0,1,0,1,1,0,1
    do_reset();
    push(8'hB4, 1'b1);
    for (int i = 0; i < 13; i++) cyc(1'b0, 1'b1);
    check("b4_lsb_seq", {24'd0, rec[7:0]}, 32'h2D);

    // Back-to-back mixed order: eight 1s, then 1, then seven 0s.
    do_reset();
    push(8'hFF, 1'b0);
    push(8'h01, 1'b1);
    for (int i = 0; i < 22; i++) cyc(1'b0, 1'b1);
    check("b2b_seq", {16'd0, rec}, 32'h0000FF80);

    // pix_en toggling: each bit held over the disabled cycle.
    do_reset();
    push(8'hA0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 18; i++) cyc(1'b0, (i % 2) == 0);
    check("toggle_seq", {24'd0, rec[7:0]}, 32'hA0);

    // Stall then underrun, then clear.
    do_reset();
    push(8'h3C, 1'b1);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1);
    check("underrun_set", {31'd0, underrun}, 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("underrun_clr", {31'd0, underrun}, 32'd0);

    // clr mid-word with hold full.
    do_reset();
    push(8'h5A, 1'b0);
    push(8'h33, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    q_data.delete();
    q_dir.delete();
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    check("mid_clr_ready", {31'd0, in_ready}, 32'd1);
    cyc(1'b0, 1'b0);

    // Randomized run.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (q_data.size() < 2 && $urandom_range(0, 2) == 0) push(W'($urandom), 1'($urandom));
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
